// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: index-width math and the arbiter state encoding.
package axis_pkg;

    localparam int MinInputs = 2;
    localparam int MaxInputs = 16;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return width;
    endfunction

    // Index width needed to name num_inputs sources; never narrower than one bit.
    function automatic int id_width_for(input int num_inputs);
        return (clog2(num_inputs) < 1) ? 1 : clog2(num_inputs);
    endfunction

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/axis_rr_arbiter_rr_priority_select.sv
// Round-robin priority pick: first set request at or above ptr, wrapping to 0.
module rr_priority_select #(
    parameter int NumInputs = 4,
    parameter int IdWidth   = 2
) (
    input  logic [NumInputs-1:0] req,
    input  logic [IdWidth-1:0]   ptr,
    output logic [IdWidth-1:0]   gnt_idx,
    output logic                 gnt_any
);

    localparam int DblWidth = 2 * NumInputs;

    logic [DblWidth-1:0] req_dbl;
    logic [DblWidth-1:0] masked;

    // Upper copy of req supplies the wrapped-around candidates once bits below ptr are masked.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves it unassigned (no latch).
        gnt_idx = '0;
        gnt_any = 1'b0;
        req_dbl = {req, req};
        masked  = req_dbl & ({DblWidth{1'b1}} << ptr);
        for (int i = DblWidth - 1; i >= 0; i--) begin
            if (masked[i]) begin
                gnt_any = 1'b1;
                gnt_idx = (i >= NumInputs) ? IdWidth'(i - NumInputs) : IdWidth'(i);
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter: shares one registered AXI-Stream master among
// NumInputs slaves, holding each grant from the first beat through tlast.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter int NumInputs = 4,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 2
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NumInputs-1:0]           s_tvalid,
    output logic [NumInputs-1:0]           s_tready,
    input  logic [NumInputs*DataWidth-1:0] s_tdata,
    input  logic [NumInputs-1:0]           s_tlast,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [DataWidth-1:0]           m_tdata,
    output logic                           m_tlast,
    output logic [IdWidth-1:0]             m_tid
);

    if (IdWidth != id_width_for(NumInputs) || NumInputs < MinInputs || NumInputs > MaxInputs) begin : g_bad_params
        $error("axis_rr_arbiter: unsupported NumInputs/IdWidth combination");
    end

    arb_state_t           state, state_nxt;
    logic [IdWidth-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IdWidth-1:0]   lock_idx, lock_idx_nxt;
    logic [IdWidth-1:0]   gnt_idx, sel_idx, sel_after;
    logic                 gnt_any, load, accept, sel_last;
    logic [DataWidth-1:0] sel_data;

    rr_priority_select #(
        .NumInputs (NumInputs),
        .IdWidth   (IdWidth)
    ) u_select (
        .req     (s_tvalid),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Source selection and the per-input ready fan-out.
    always_comb begin
        load      = ~m_tvalid | m_tready;
        sel_idx   = (state == LOCKED) ? lock_idx : gnt_idx;
        s_tready  = '0;
        if (aresetn && (state == LOCKED || gnt_any)) begin
            s_tready[sel_idx] = load;
        end
        accept    = s_tvalid[sel_idx] & s_tready[sel_idx];
        sel_last  = s_tlast[sel_idx];
        sel_data  = s_tdata[sel_idx*DataWidth +: DataWidth];
        // Explicit compare so non-power-of-two input counts wrap correctly.
        sel_after = (sel_idx == IdWidth'(NumInputs - 1)) ? '0 : sel_idx + 1'b1;
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        lock_idx_nxt = lock_idx;
        if (accept) begin
            if (sel_last) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = sel_after;
            end else begin
                state_nxt    = LOCKED;
                lock_idx_nxt = sel_idx;
            end
        end
    end

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!aresetn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
            m_tvalid <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            lock_idx <= lock_idx_nxt;
            if (load) begin
                m_tvalid <= accept;
            end
        end
    end

    // NOTE: payload registers are deliberately not reset; m_tvalid alone qualifies them.
    always_ff @(posedge aclk) begin
        if (accept) begin
            m_tdata <= sel_data;
            m_tlast <= sel_last;
            m_tid   <= sel_idx;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: per-cycle reference model, directed packets, random stress.
module tb_axis_rr_arbiter;

    localparam int NUM  = 4;
    localparam int DW   = 32;
    localparam int IW   = 2;
    localparam int RING = 32;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [NUM-1:0]    s_tvalid, s_tready, s_tlast;
    logic [NUM*DW-1:0] s_tdata;
    logic              m_tvalid, m_tready, m_tlast;
    logic [DW-1:0]     m_tdata;
    logic [IW-1:0]     m_tid;

    always #5 aclk = ~aclk;

    axis_rr_arbiter #(.NumInputs(NUM), .DataWidth(DW), .IdWidth(IW)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- source rings (one per input) ----------------
    logic [DW:0]    ring [NUM][RING];
    int             rd_ptr [NUM];
    int             cnt [NUM];
    logic [NUM-1:0] offer;

    task automatic push(input int k, input logic [DW-1:0] d, input logic l);
        ring[k][(rd_ptr[k] + cnt[k]) % RING] = {l, d};
        cnt[k]++;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NUM; k++) begin
            s_tvalid[k] = offer[k] && (cnt[k] > 0);
            if (cnt[k] > 0) begin
                {s_tlast[k], s_tdata[k*DW +: DW]} = ring[k][rd_ptr[k]];
            end else begin
                s_tlast[k]          = 1'b0;
                s_tdata[k*DW +: DW] = '0;
            end
        end
    endtask

    // One clock: record handshakes at negedge, pop them after the edge, re-drive, settle.
    task automatic tick();
        logic [NUM-1:0] hs;
        @(negedge aclk);
        hs = s_tvalid & s_tready;
        @(posedge aclk);
        #1;
        for (int k = 0; k < NUM; k++) begin
            if (hs[k]) begin
                rd_ptr[k] = (rd_ptr[k] + 1) % RING;
                cnt[k]--;
            end
        end
        drive_inputs();
        #1;
    endtask

    // ---------------- reference model + output log ----------------
    typedef struct packed {
        logic [IW-1:0] id;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         out_log [$];
    int            log_cyc [$];
    int            cyc = 0;
    bit            model_ok = 1'b0;
    bit            mv, ml, locked, stress = 1'b0;
    logic [DW-1:0] md;
    int            mid, owner, rr, open_id;
    int            exp_seq [NUM];
    int            gen_seq [NUM];

    always @(negedge aclk) begin : model
        logic [NUM-1:0] exp_rdy;
        int             g;
        bit             load;
        cyc++;
        if (model_ok) begin
            check("m_tvalid", m_tvalid, mv);
            if (mv) begin
                check("m_tdata", m_tdata, md);
                check("m_tlast", m_tlast, ml);
                check("m_tid", m_tid, mid);
            end
            if (m_tvalid && m_tready) begin
                out_log.push_back('{id: m_tid, last: m_tlast, data: m_tdata});
                log_cyc.push_back(cyc);
                if (stress) begin
                    check("sb_src", m_tdata[31:24], m_tid);
                    check("sb_seq", m_tdata[23:0], 24'(exp_seq[m_tid]));
                    exp_seq[m_tid]++;
                    if (open_id >= 0) check("sb_interleave", m_tid, open_id);
                    open_id = m_tlast ? -1 : int'(m_tid);
                end
            end
        end
        exp_rdy = '0;
        g       = -1;
        if (!aresetn) begin
            check("s_tready_in_reset", s_tready, '0);
            mv       = 1'b0;
            locked   = 1'b0;
            rr       = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            load = !mv || m_tready;
            if (locked) begin
                g = owner;
            end else begin
                for (int i = 0; i < NUM; i++) begin
                    if (g < 0 && s_tvalid[(rr + i) % NUM]) g = (rr + i) % NUM;
                end
            end
            if (g >= 0 && load) exp_rdy[g] = 1'b1;
            check("s_tready", s_tready, exp_rdy);
            if (g >= 0 && load && s_tvalid[g]) begin
                mv  = 1'b1;
                md  = s_tdata[g*DW +: DW];
                ml  = s_tlast[g];
                mid = g;
                if (ml) begin
                    locked = 1'b0;
                    rr     = (g + 1) % NUM;
                end else begin
                    locked = 1'b1;
                    owner  = g;
                end
            end else if (load) begin
                mv = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed tests + stress ----------------
    initial begin
        int base;
        int n;
        int hits;
        logic [IW-1:0] t1_ids [12];
        logic [IW-1:0] t3_ids [6];
        logic [DW-1:0] t3_dat [6];
        t1_ids = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
        t3_ids = '{1, 1, 1, 1, 2, 0};
        t3_dat = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h21, 32'h01};

        aresetn  = 1'b0;
        m_tready = 1'b1;
        offer    = '0;
        open_id  = -1;
        for (int k = 0; k < NUM; k++) begin
            rd_ptr[k]  = 0;
            cnt[k]     = 0;
            exp_seq[k] = 0;
            gen_seq[k] = 0;
        end
        drive_inputs();
        tick();
        tick();
        check("reset_m_tvalid", m_tvalid, 1'b0);
        check("reset_s_tready", s_tready, '0);
        aresetn = 1'b1;

        // T1: four simultaneous 3-beat packets
        base = out_log.size();
        for (int k = 0; k < NUM; k++)
            for (int j = 0; j < 3; j++) push(k, 32'h100 * k + j, j == 2);
        offer = '1;
        drive_inputs();
        for (n = 0; n < 40 && out_log.size() - base < 12; n++) tick();
        check("t1_beats", out_log.size() - base, 12);
        if (out_log.size() - base >= 12) begin
            for (int i = 0; i < 12; i++) begin
                check("t1_tid", out_log[base+i].id, t1_ids[i]);
                check("t1_tlast", out_log[base+i].last, (i % 3) == 2);
            end
            check("t1_no_bubble", log_cyc[base+11] - log_cyc[base], 11);
        end
        offer = '0;
        drive_inputs();

        // T2: lone requester, single-beat packets back to back
        base = out_log.size();
        for (int j = 0; j < 5; j++) push(2, 32'hA0 + j, 1'b1);
        offer = 4'b0100;
        drive_inputs();
        for (n = 0; n < 30 && out_log.size() - base < 5; n++) tick();
        check("t2_beats", out_log.size() - base, 5);
        if (out_log.size() - base >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check("t2_tid", out_log[base+i].id, 2);
                check("t2_data", out_log[base+i].data, 32'hA0 + i);
                check("t2_tlast", out_log[base+i].last, 1'b1);
            end
            check("t2_back_to_back", log_cyc[base+4] - log_cyc[base], 4);
        end

        // T3: input 1 locked mid-packet while inputs 0 and 2 raise valid
        base = out_log.size();
        for (int j = 0; j < 4; j++) push(1, 32'h10 + j, j == 3);
        offer = 4'b0010;
        drive_inputs();
        for (n = 0; n < 20 && cnt[1] > 2; n++) tick();
        check("t3_two_accepted", cnt[1], 2);
        push(0, 32'h01, 1'b1);
        push(2, 32'h21, 1'b1);
        offer = 4'b0111;
        drive_inputs();
        #1;
        check("t3_locked_rdy_a", s_tready, 4'b0010);
        tick();
        check("t3_locked_rdy_b", s_tready, 4'b0010);
        tick();
        check("t3_next_is_2", s_tready, 4'b0100);
        tick();
        check("t3_then_0", s_tready, 4'b0001);
        for (n = 0; n < 20 && out_log.size() - base < 6; n++) tick();
        check("t3_beats", out_log.size() - base, 6);
        if (out_log.size() - base >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check("t3_tid", out_log[base+i].id, t3_ids[i]);
                check("t3_data", out_log[base+i].data, t3_dat[i]);
            end
        end
        offer = '0;
        drive_inputs();
        tick();

        // T4: output backpressure holds the registered beat
        m_tready = 1'b0;
        push(3, 32'h1234, 1'b1);
        push(3, 32'h5678, 1'b1);
        offer = 4'b1000;
        drive_inputs();
        tick();
        base = out_log.size();
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", m_tvalid, 1'b1);
            check("t4_hold_data", m_tdata, 32'h1234);
            check("t4_hold_tid", m_tid, 3);
            check("t4_hold_last", m_tlast, 1'b1);
            check("t4_no_ready", s_tready, '0);
            tick();
        end
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        hits = 0;
        for (int i = base; i < out_log.size(); i++) if (out_log[i].data == 32'h1234) hits++;
        check("t4_single_transfer", hits, 1);
        check("t4_first_out", out_log.size() > base ? out_log[base].data : 32'hX, 32'h1234);
        offer = '0;
        drive_inputs();

        // T5: reset while locked on input 3
        for (int j = 0; j < 4; j++) push(3, 32'h30 + j, j == 3);
        offer = 4'b1000;
        drive_inputs();
        for (n = 0; n < 20 && cnt[3] > 2; n++) tick();
        check("t5_locked", cnt[3], 2);
        aresetn = 1'b0;
        tick();
        check("t5_rst_m_tvalid", m_tvalid, 1'b0);
        check("t5_rst_s_tready", s_tready, '0);
        cnt[3]  = 0;
        aresetn = 1'b1;
        for (int k = 0; k < NUM; k++) push(k, 32'h40 + k, 1'b1);
        offer = '1;
        drive_inputs();
        #1;
        check("t5_input0_wins", s_tready, 4'b0001);
        base = out_log.size();
        for (n = 0; n < 20 && out_log.size() - base < 4; n++) tick();
        check("t5_beats", out_log.size() - base, 4);
        if (out_log.size() - base >= 4)
            for (int i = 0; i < 4; i++) check("t5_tid", out_log[base+i].id, i);
        for (n = 0; n < 40 && (cnt[0] + cnt[1] + cnt[2] + cnt[3] > 0 || m_tvalid); n++) tick();
        check("t5_drained", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);

        // T6: random valid/ready stress with per-input sequence scoreboard
        stress  = 1'b1;
        open_id = -1;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < NUM; k++) begin
                if (cnt[k] < 4) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) begin
                        push(k, {8'(k), 24'(gen_seq[k])}, j == len - 1);
                        gen_seq[k]++;
                    end
                end
            end
            offer    = NUM'($urandom);
            m_tready = ($urandom_range(0, 9) < 7);
            drive_inputs();
            tick();
        end
        offer    = '1;
        m_tready = 1'b1;
        drive_inputs();
        for (n = 0; n < 200 && (cnt[0] + cnt[1] + cnt[2] + cnt[3] > 0 || m_tvalid); n++) tick();
        tick();
        for (int k = 0; k < NUM; k++) check("t6_all_delivered", exp_seq[k], gen_seq[k]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Packet-aware round-robin arbiter. Shares one AXI-Stream output, which feeds a downstream pipeline buffer or processing core, among NumInputs AXI-Stream requesters.
- Grants one input at a time and holds the grant until that input's tlast beat.
- Output is registered (1 stage), so the block provides its own timing isolation toward the shared datapath.

Parameters:
- NumInputs, 4, number of requesting slave streams (2..16)
- DataWidth, 32, tdata width in bits
- IdWidth, 2, width of m_tid; must equal max(1, clog2(NumInputs))

Ports:
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  synchronous, active-low reset
- s_tvalid  in  NumInputs  per-input valid; bit k belongs to input k
- s_tready  out  NumInputs  per-input ready
- s_tdata  in  NumInputs*DataWidth  input k occupies bits [k*DataWidth +: DataWidth]
- s_tlast  in  NumInputs  per-input end-of-packet
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tdata  out  DataWidth  output data
- m_tlast  out  1  output end-of-packet
- m_tid  out  IdWidth  index of the input that sourced the current output beat

Behaviour:
- Reset is synchronous, active-low, on aclk. While aresetn=0:
  - m_tvalid=0, s_tready=all 0
  - state=IDLE, rr pointer=0
  - m_tdata/m_tlast/m_tid hold don't-care register contents
- Output stage:
  - load = ~m_tvalid | m_tready.
  - Input-to-output latency is exactly 1 cycle: a beat accepted at edge N appears on m_* after edge N.
  - Full throughput, 1 beat/cycle, while m_tready=1.
  - m_* is stable while m_tvalid=1 and m_tready=0.
- Arbitration state machine:
  - IDLE:
    - Grant g = first k with s_tvalid[k]=1, searching upward from rr pointer and wrapping modulo NumInputs.
    - s_tready[g] = load; every other s_tready bit = 0.
    - If no s_tvalid bit is set, all s_tready bits are 0 and the state stays IDLE.
  - On acceptance (s_tvalid[g] & s_tready[g]):
    - Register the beat with m_tid=g.
    - If s_tlast[g]=1 (single-beat packet): stay IDLE, pointer <= (g+1) mod NumInputs.
    - Otherwise: state <= LOCKED, lock <= g.
  - LOCKED:
    - s_tready[lock] = load; all other s_tready bits = 0, regardless of other valids.
    - Accepting a beat with s_tlast[lock]=1 moves to IDLE and sets pointer <= (lock+1) mod NumInputs.
    - The next grant is evaluated combinationally in the cycle after that edge. There is therefore no bubble between packets from different inputs.
- s_tready is combinational from s_tvalid, the state, and m_tready. The block never asserts s_tready on an input whose s_tvalid is low, except the locked input in LOCKED.
- Fairness: any input holding s_tvalid waits at most NumInputs-1 packets.
- Boundary cases:
  - A lone active requester gets back-to-back packets; the pointer wraps to itself.
  - A locked input dropping s_tvalid mid-packet stalls the arbiter, which stays LOCKED with no grant change.
  - Reset asserted mid-packet discards the lock and the output beat. The upstream sees no further s_tready until the packet restarts after reset.
  - m_tready=0 with m_tvalid=1 forces all s_tready bits to 0.
  - NumInputs that is not a power of 2: pointer wrap uses an explicit compare, not bit truncation.

Decomposition:
- Shared package axis_pkg:
  - function clog2
  - localparam helper for the IdWidth check
  - arbiter state encoding: IDLE=1'b0, LOCKED=1'b1
- One sub-module, rr_priority_select: purely combinational.
  - Inputs: req[NumInputs], ptr[IdWidth].
  - Outputs: gnt_idx[IdWidth], gnt_any.
  - Implementation: double-width request vector masking.
- The top level holds the FSM, pointer, lock, and output register.

Test Plan:
- Reset, then NumInputs=4, inputs 0..3 each present one 3-beat packet simultaneously, m_tready=1 -> output m_tid sequence 0,0,0,1,1,1,2,2,2,3,3,3 with no idle cycles; m_tlast on beats 3,6,9,12.
- Input 2 alone sends single-beat packets 0xA0..0xA4 back-to-back -> 5 consecutive output beats, m_tid=2, m_tlast=1 each, 1 cycle latency.
- Input 1 is LOCKED mid-packet (beat 2 of 4) and input 0 raises valid -> s_tready[0] stays 0 until input 1's tlast beat is accepted; next grant goes to input 2 if valid, else 3, else 0.
- Output backpressure: m_tready=0 for 5 cycles while m_tvalid=1 with data 0x1234 -> m_tdata/m_tid/m_tlast hold, all s_tready=0; 0x1234 transfers once on release.
- Reset asserted for 1 cycle while LOCKED on input 3 -> next cycle m_tvalid=0, state IDLE, pointer=0; with all inputs valid, input 0 wins first.
- Random valid/ready stress, 10k cycles, scoreboard per input -> no lost, duplicated, or interleaved-within-packet beats; m_tid always matches the source.
